// File: rtl/fifo_pop_stream.sv
// Pop-side drain engine: credit-limited POP issue, RD_LAT realignment, skid buffer and flush sequencer.
// Optional delivered-word counter enabled by FIFO_POP_STREAM_STATS_EN.
module fifo_pop_stream #(
    parameter int DATA_WIDTH = 36,
    parameter int RD_LAT     = 1,
    parameter int FLAG_LAT   = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  Pop_Clk,
    input  logic                  Pop_Rst_n,
    input  logic [3:0]            POP_FLAG,
    input  logic [DATA_WIDTH-1:0] DOUT,
    output logic                  POP,
    output logic                  Pop_Clk_En,
    output logic                  Fifo_Pop_Flush,
    input  logic                  Flush_Req,
    output logic                  Flush_Busy,
    output logic [DATA_WIDTH-1:0] M_Data,
    output logic                  M_Valid,
    input  logic                  M_Ready,
    output logic [15:0]           Word_Count
);
    localparam int AW = $clog2(SKID_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] DEPTH_W = (PW+1)'(SKID_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH, S_SETTLE} state_t;

    state_t                r_state;
    logic [FLAG_LAT-1:0]   r_pop_hist;
    logic [RD_LAT-1:0]     r_land_pipe;
    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [1:0]            r_settle_cnt;
    logic                  r_armed;
    logic                  r_fifo_flush;
    logic                  r_flush_busy;

    logic [1:0]            w_min_entries;
    logic [1:0]            w_recent;
    logic [PW-1:0]         w_inflight;
    logic [PW-1:0]         w_occ;
    logic [RD_LAT-1:0]     w_pipe_after;
    logic                  w_pop;
    logic                  w_land;
    logic                  w_deq;
    logic                  w_drained;

    always_comb begin
        unique case (POP_FLAG)
            4'h0:    w_min_entries = 2'd0;
            4'h1:    w_min_entries = 2'd1;
            default: w_min_entries = 2'd2;
        endcase
    end

    always_comb begin
        w_recent = '0;
        for (int unsigned i = 0; i < FLAG_LAT; i++) w_recent = w_recent + 2'(r_pop_hist[i]);
        w_inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) w_inflight = w_inflight + PW'(r_land_pipe[i]);
    end

    assign w_occ        = r_wptr - r_rptr;
    assign w_land       = r_land_pipe[RD_LAT-1];
    assign M_Valid      = (w_occ != '0);
    assign w_deq        = M_Valid && M_Ready;
    assign M_Data       = r_mem[r_rptr[AW-1:0]];
    // the entry landing this cycle no longer counts once the edge passes
    assign w_pipe_after = r_land_pipe << 1;
    assign w_drained    = (w_pipe_after == '0);

    assign w_pop = Pop_Rst_n && r_armed && (r_state == S_RUN) && (w_min_entries > w_recent)
                   && (({1'b0, w_occ} + {1'b0, w_inflight}) < DEPTH_W);

    assign POP            = w_pop;
    assign Pop_Clk_En     = 1'b1;
    assign Fifo_Pop_Flush = r_fifo_flush;
    assign Flush_Busy     = r_flush_busy;

    always_ff @(posedge Pop_Clk) begin
        if (!Pop_Rst_n) begin
            r_state      <= S_RUN;
            r_pop_hist   <= '0;
            r_land_pipe  <= '0;
            r_settle_cnt <= '0;
            r_armed      <= 1'b0;
            r_fifo_flush <= 1'b0;
            r_flush_busy <= 1'b0;
        end else begin
            r_armed      <= 1'b1;
            r_pop_hist   <= (r_pop_hist << 1) | FLAG_LAT'(w_pop);
            r_land_pipe  <= (r_land_pipe << 1) | RD_LAT'(w_pop);
            r_fifo_flush <= 1'b0;
            unique case (r_state)
                S_RUN: begin
                    if (Flush_Req) begin
                        r_state      <= S_DRAIN;
                        r_flush_busy <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_state      <= S_FLUSH;
                        r_fifo_flush <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_state      <= S_SETTLE;
                    r_settle_cnt <= 2'(FLAG_LAT - 1);
                end
                S_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state      <= S_RUN;
                        r_flush_busy <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge Pop_Clk) begin
        if (!Pop_Rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int unsigned i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
        end else if (r_state == S_FLUSH) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_land) begin
                r_mem[r_wptr[AW-1:0]] <= DOUT;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_deq) r_rptr <= r_rptr + 1'b1;
        end
    end

    // credit rule makes a land into a full buffer impossible
    always_ff @(posedge Pop_Clk) begin
        if (Pop_Rst_n && w_land && !w_deq) assert (w_occ < PW'(SKID_DEPTH));
    end

`ifdef FIFO_POP_STREAM_STATS_EN
    logic [15:0] r_word_count;

    always_ff @(posedge Pop_Clk) begin
        if (!Pop_Rst_n)                          r_word_count <= '0;
        else if (r_state == S_FLUSH)             r_word_count <= '0;
        else if (w_deq && (r_word_count != '1))  r_word_count <= r_word_count + 1'b1;
    end

    assign Word_Count = r_word_count;
`else
    assign Word_Count = '0;
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Scoreboard bench for fifo_pop_stream: FIFO model feeds POP_FLAG/DOUT, monitor checks the stream.
module tb_fifo_pop_stream;
    localparam int DW  = 36;
    localparam int RDL = 1;
    localparam int FLL = 2;
    localparam int SD  = 4;
`ifdef FIFO_POP_STREAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [DW-1:0] JUNK = 36'hBADBADBAD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    POP_FLAG;
    logic [DW-1:0] DOUT;
    logic          POP, Pop_Clk_En, Fifo_Pop_Flush, Flush_Req, Flush_Busy;
    logic [DW-1:0] M_Data;
    logic          M_Valid, M_Ready;
    logic [15:0]   Word_Count;

    fifo_pop_stream #(.DATA_WIDTH(DW), .RD_LAT(RDL), .FLAG_LAT(FLL), .SKID_DEPTH(SD)) dut (
        .Pop_Clk(clk), .Pop_Rst_n(rst_n), .POP_FLAG(POP_FLAG), .DOUT(DOUT), .POP(POP),
        .Pop_Clk_En(Pop_Clk_En), .Fifo_Pop_Flush(Fifo_Pop_Flush), .Flush_Req(Flush_Req),
        .Flush_Busy(Flush_Busy), .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready),
        .Word_Count(Word_Count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] w;
    } rd_t;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    rd_t           rd_q[$];
    int unsigned   sz_hist[FLL];
    bit            flag_force = 1'b0;
    logic [3:0]    flag_force_val = 4'h0;
    int            n_popped = 0, n_deliv = 0;
    int            errors = 0, checks = 0;
    int            first_pop = -1, first_val = -1;
    int unsigned   wc_model = 0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // FIFO model: read data RDL cycles after POP, flag shows size FLL cycles late
    initial begin
        foreach (sz_hist[i]) sz_hist[i] = 0;
        forever begin
            @(posedge clk);
            #2;
            DOUT = JUNK;
            while (rd_q.size() != 0 && rd_q[0].due < cyc) void'(rd_q.pop_front());
            if (rd_q.size() != 0 && rd_q[0].due == cyc) DOUT = rd_q.pop_front().w;
            if (flag_force) POP_FLAG = flag_force_val;
            else            POP_FLAG = (sz_hist[FLL-1] > 15) ? 4'hF : 4'(sz_hist[FLL-1]);
        end
    end

    // monitor: stream scoreboard, hold rule, over-read and credit checks
    initial begin
        forever begin
            @(negedge clk);
            if (prev_hold) chk("hold", {M_Valid, M_Data}, {1'b1, prev_data});
            if (M_Valid && first_val < 0) first_val = int'(cyc);
            if (rst_n && M_Valid && M_Ready) begin
                chk("word_count", 64'(Word_Count), STATS ? 64'(wc_model) : 64'd0);
                if (exp_q.size() == 0) chk("spurious", 64'(M_Data), 64'(JUNK));
                else                   chk("data", 64'(M_Data), 64'(exp_q.pop_front()));
                n_deliv++;
                if (wc_model < 16'hFFFF) wc_model++;
            end
            prev_hold = rst_n && M_Valid && !M_Ready && !Fifo_Pop_Flush;
            prev_data = M_Data;
            if (POP) begin
                chk("overread", 64'(fifo_q.size() == 0), 64'd0);
                if (fifo_q.size() != 0) begin
                    rd_q.push_back('{due: cyc + RDL, w: fifo_q.pop_front()});
                    n_popped++;
                    chk("credit", 64'(n_popped - n_deliv > SD), 64'd0);
                    if (first_pop < 0) first_pop = int'(cyc);
                end
            end
            if (!rst_n) begin
                while (n_popped > n_deliv) begin
                    void'(exp_q.pop_front());
                    n_popped--;
                end
                wc_model = 0;
            end
            if (Fifo_Pop_Flush) begin
                exp_q.delete();
                fifo_q.delete();
                n_popped = n_deliv;
                wc_model = 0;
            end
            for (int i = FLL - 1; i > 0; i--) sz_hist[i] = sz_hist[i-1];
            sz_hist[0] = fifo_q.size();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            step();
            k++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (6) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pop"},   64'(POP), 64'd0);
        chk({tag, "_clken"}, 64'(Pop_Clk_En), 64'd1);
        chk({tag, "_flush"}, 64'(Fifo_Pop_Flush), 64'd0);
        chk({tag, "_busy"},  64'(Flush_Busy), 64'd0);
        chk({tag, "_valid"}, 64'(M_Valid), 64'd0);
        chk({tag, "_mdata"}, 64'(M_Data), 64'd0);
        chk({tag, "_wc"},    64'(Word_Count), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, t, f, flush_cnt, busy_drop, pops_busy, busy_t1, mv_after, wc_after, k;
        rst_n = 1'b0; M_Ready = 1'b0; Flush_Req = 1'b0; DOUT = '0; POP_FLAG = 4'h0;
        repeat (2) step();
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // five words, always ready: in order, five POPs, valid two cycles after first POP
        first_pop = -1; first_val = -1; p0 = n_popped;
        M_Ready = 1'b1;
        load(5, 36'h1);
        wait_drain(100, "t1_drain");
        chk("t1_pops", 64'(n_popped - p0), 64'd5);
        chk("t1_latency", 64'(first_val - first_pop), 64'(1 + RDL));

        // single entry at flag 1: exactly one POP
        p0 = n_popped;
        load(1, 36'h21);
        repeat (12) step();
        chk("t2_pops", 64'(n_popped - p0), 64'd1);
        chk("t2_left", 64'(exp_q.size()), 64'd0);

        // flag held at 1: POPs spaced FLAG_LAT+1 apart -> 4 in 12 cycles
        flag_force = 1'b1; flag_force_val = 4'h0;
        load(6, 36'h31);
        repeat (4) step();
        p0 = n_popped;
        flag_force_val = 4'h1;
        repeat (12) step();
        chk("t2b_pops", 64'(n_popped - p0), 64'd4);
        flag_force = 1'b0;
        wait_drain(100, "t2b_drain");

        // stalled consumer: buffer fills, POP stops at SKID_DEPTH, head held
        M_Ready = 1'b0;
        p0 = n_popped;
        load(10, 36'h100);
        repeat (20) step();
        chk("t3_pops", 64'(n_popped - p0), 64'(SD));
        chk("t3_valid", 64'(M_Valid), 64'd1);
        chk("t3_head", 64'(M_Data), 64'(exp_q[0]));
        M_Ready = 1'b1;
        wait_drain(200, "t3_drain");
        chk("t3_total", 64'(n_popped - p0), 64'd10);

        // random back-pressure over 1000 words
        load(1000, 36'hA5A5A0000);
        k = 0;
        while (exp_q.size() != 0 && k < 20000) begin
            M_Ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        M_Ready = 1'b1;
        chk("t4_drain", 64'(exp_q.size()), 64'd0);
        repeat (6) step();

        // flush while streaming
        load(10, 36'h200);
        repeat (3) step();
        Flush_Req = 1'b1;
        t = int'(cyc);
        step();
        Flush_Req = 1'b0;
        f = -1; flush_cnt = 0; busy_drop = -1; pops_busy = 0; busy_t1 = -1; mv_after = -1; wc_after = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (int'(cyc) == t + 1) busy_t1 = int'(Flush_Busy);
            if (Fifo_Pop_Flush) begin
                flush_cnt++;
                if (f < 0) f = int'(cyc);
            end
            if (f >= 0 && int'(cyc) == f + 1) begin
                mv_after = int'(M_Valid);
                wc_after = int'(Word_Count);
            end
            if (Flush_Busy && POP) pops_busy++;
            if (!Flush_Busy && busy_drop < 0) busy_drop = int'(cyc);
        end
        chk("t5_busy_t1", 64'(busy_t1), 64'd1);
        chk("t5_flush_cycle", 64'(f - t), 64'(1 + RDL));
        chk("t5_flush_pulses", 64'(flush_cnt), 64'd1);
        chk("t5_valid_after", 64'(mv_after), 64'd0);
        chk("t5_wc_after", 64'(wc_after), 64'd0);
        chk("t5_pops_busy", 64'(pops_busy), 64'd0);
        chk("t5_busy_release", 64'(busy_drop - f), 64'(FLL + 1));
        step();
        load(3, 36'h300);
        wait_drain(100, "t5_resume");

        // one-cycle reset while streaming
        load(10, 36'h400);
        repeat (4) step();
        rst_n = 1'b0;
        M_Ready = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6");
        step();
        M_Ready = 1'b1;
        wait_drain(200, "t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
